// File: rtl/multiport_grf.sv
`default_nettype none
// ============================================================================
// Module   : multiport_grf
// Brief    : Multi-read, dual-write register file with same-cycle write bypass
//            and per-register pending scoreboard. Optional macro GRF_TRACE_EN
//            prints every accepted write.
// Revision : 1.0
// ============================================================================
module multiport_grf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_ready,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic [31:0]                wr0_pc,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic [31:0]                wr1_pc,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic [(2**ADDR_W)-1:0]     pend_vec
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [DEPTH-1:0]  w_pend_nxt;
    logic              w_wr0_act;
    logic              w_wr1_act;
    logic              w_iss_act;

    assign w_wr0_act = wr0_en && (wr0_addr != '0);
    assign w_wr1_act = wr1_en && (wr1_addr != '0);
    assign w_iss_act = iss_en && (iss_addr != '0);

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            if (w_wr0_act) r_regs[wr0_addr] <= wr0_data;
            if (w_wr1_act) r_regs[wr1_addr] <= wr1_data;
        end
    end

    // A new reservation overrides a completing write to the same register.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr0_act) w_pend_nxt[wr0_addr] = 1'b0;
        if (w_wr1_act) w_pend_nxt[wr1_addr] = 1'b0;
        if (w_iss_act) w_pend_nxt[iss_addr] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign pend_vec = r_pend;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        logic [DATA_W-1:0] w_data;
        logic              w_ready;

        assign w_a = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            w_data  = r_regs[w_a];
            w_ready = !r_pend[w_a];
            if (w_a == '0) begin
                w_data  = '0;
                w_ready = 1'b1;
            end else if (wr1_en && (wr1_addr == w_a)) begin
                w_data  = wr1_data;
                w_ready = 1'b1;
            end else if (wr0_en && (wr0_addr == w_a)) begin
                w_data  = wr0_data;
                w_ready = 1'b1;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = w_data;
        assign rd_ready[i]                 = w_ready;
    end

`ifdef GRF_TRACE_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (w_wr0_act) $display("%d@%h: $%d <= %h", $time, wr0_pc, wr0_addr, wr0_data);
            if (w_wr1_act) $display("%d@%h: $%d <= %h", $time, wr1_pc, wr1_addr, wr1_data);
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^{wr0_pc, wr1_pc};
`endif

endmodule
`default_nettype wire
